// File: rtl/conv_window_gen_if.sv
// rtl/conv_window_gen_if.sv - pixel-in / window-out handshake bundle for conv_window_gen
interface conv_window_gen_if #(
  parameter int KERNEL_SIZE    = 3,
  parameter int PX_SIZE        = 8,
  parameter int INPUT_CHANNELS = 1,
  parameter int IMG_WIDTH      = 8,
  parameter int IMG_HEIGHT     = 8
);
  logic                                                              in_valid;
  logic                                                              in_ready;
  logic [INPUT_CHANNELS-1:0][PX_SIZE-1:0]                            in_px;
  logic                                                              win_valid;
  logic                                                              win_ready;
  logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][INPUT_CHANNELS-1:0][PX_SIZE-1:0] win;
  logic [$clog2(IMG_WIDTH)-1:0]                                      win_col;
  logic [$clog2(IMG_HEIGHT)-1:0]                                     win_row;
  logic                                                              win_last;

  // master: pixel source + window consumer; slave: the window generator
  modport master (
    output in_valid, in_px, win_ready,
    input  in_ready, win_valid, win, win_col, win_row, win_last
  );

  modport slave (
    input  in_valid, in_px, win_ready,
    output in_ready, win_valid, win, win_col, win_row, win_last
  );
endinterface

// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - raster-order KxK sliding window generator with K-1 line buffers
module conv_window_gen #(
  parameter int KERNEL_SIZE    = 3,
  parameter int PX_SIZE        = 8,
  parameter int INPUT_CHANNELS = 1,
  parameter int IMG_WIDTH      = 8,
  parameter int IMG_HEIGHT     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  conv_window_gen_if.slave  bus
);
  localparam int K  = KERNEL_SIZE;
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  typedef logic [INPUT_CHANNELS-1:0][PX_SIZE-1:0]               px_t;
  typedef logic [K-1:0][INPUT_CHANNELS-1:0][PX_SIZE-1:0]        col_t;
  typedef logic [K-1:0][K-1:0][INPUT_CHANNELS-1:0][PX_SIZE-1:0] win_t;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  px_t           line_buf [0:K-2][0:IMG_WIDTH-1];
  win_t          shift_win;
  win_t          next_win;
  col_t          new_col;

  logic          win_valid_q;
  win_t          win_q;
  logic [CW-1:0] win_col_q;
  logic [RW-1:0] win_row_q;
  logic          win_last_q;

  logic          accept;
  logic          produce;
  logic          at_row_end;
  logic          at_last_row;

  assign bus.in_ready  = rst_n && (!win_valid_q || bus.win_ready);
  assign bus.win_valid = win_valid_q;
  assign bus.win       = win_q;
  assign bus.win_col   = win_col_q;
  assign bus.win_row   = win_row_q;
  assign bus.win_last  = win_last_q;

  assign accept      = bus.in_valid && bus.in_ready;
  assign at_row_end  = (col == CW'(IMG_WIDTH - 1));
  assign at_last_row = (row == RW'(IMG_HEIGHT - 1));
  assign produce     = accept && (col >= CW'(K - 1)) && (row >= RW'(K - 1));

  // line_buf[0] holds the oldest row, so it feeds the top (y=0) of the new column
  always_comb begin
    new_col = '0;
    for (int y = 0; y < K - 1; y++) begin
      new_col[y] = line_buf[y][col];
    end
    new_col[K-1] = bus.in_px;

    next_win = shift_win;
    for (int x = 0; x < K - 1; x++) begin
      next_win[x] = shift_win[x+1];
    end
    next_win[K-1] = new_col;
  end

  // Datapath storage is not reset: the first K-1 rows of a frame overwrite every entry a window uses
  always_ff @(posedge clk) begin
    if (accept) begin
      shift_win <= next_win;
      for (int y = 0; y < K - 2; y++) begin
        line_buf[y][col] <= line_buf[y+1][col];
      end
      line_buf[K-2][col] <= bus.in_px;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col         <= '0;
      row         <= '0;
      win_valid_q <= 1'b0;
      win_q       <= '0;
      win_col_q   <= '0;
      win_row_q   <= '0;
      win_last_q  <= 1'b0;
    end else if (accept) begin
      if (at_row_end) begin
        col <= '0;
        row <= at_last_row ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end

      // an accept always retires any held window, so valid simply follows produce
      win_valid_q <= produce;
      if (produce) begin
        win_q      <= next_win;
        win_col_q  <= col - CW'(K - 1);
        win_row_q  <= row - RW'(K - 1);
        win_last_q <= at_row_end && at_last_row;
      end
    end else if (bus.win_ready) begin
      win_valid_q <= 1'b0;
    end
  end
endmodule
